// File: rtl/ans_pkg.sv
// ans_pkg: widths, FSM states and table reset values shared by the ANS front end.
package ans_pkg;
  localparam int DEF_SYM_WIDTH = 4;
  localparam int DEF_CNT_WIDTH = 8;
  localparam int DEF_STATE_WIDTH = 16;
  localparam int DEF_DEPTH = 16;
  typedef enum logic [2:0] {IDLE, FILL, DRAIN_ISSUE, DRAIN_CHECK, DRAIN_WAIT, DONE} state_t;
  function automatic logic [31:0] uniform_cum(input int unsigned i);
    return 32'(i);
  endfunction
endpackage

// File: rtl/ans_sym_lifo.sv
// ans_sym_lifo: symbol stack feeding the encoder in reverse arrival order.
module ans_sym_lifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] below,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign top = mem[AW'(count - CW'(1))];
  assign below = mem[AW'(count - CW'(2))];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[count[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (push && !pop) count <= count + CW'(1);
    else if (pop && !push) count <= count - CW'(1);
endmodule

// File: rtl/ans_enc_sched.sv
// ans_enc_sched: buffers a symbol block, looks up frequencies and sequences the
// encoder handshake, re-presenting a symbol whenever the encoder emits instead.
module ans_enc_sched import ans_pkg::*; #(
  parameter int SYM_WIDTH = DEF_SYM_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int STATE_WIDTH = DEF_STATE_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [SYM_WIDTH-1:0]   cfg_sym,
  input  logic [CNT_WIDTH-1:0]   cfg_count,
  input  logic [STATE_WIDTH-1:0] cfg_cum,
  input  logic                   cfg_total_we,
  input  logic [STATE_WIDTH-1:0] cfg_total,
  input  logic [SYM_WIDTH-1:0]   sym_in,
  input  logic                   sym_last,
  input  logic                   sym_vld,
  output logic                   sym_rdy,
  output logic [CNT_WIDTH-1:0]   enc_count,
  output logic [STATE_WIDTH-1:0] enc_cum,
  output logic [STATE_WIDTH-1:0] enc_total,
  output logic                   enc_vld,
  input  logic                   enc_rdy,
  output logic                   busy,
  output logic                   blk_done,
  output logic                   err_zero
);
  localparam int N = 2**SYM_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt_tab [N];
  logic [STATE_WIDTH-1:0] cum_tab [N];
  logic [STATE_WIDTH-1:0] total;
  logic [SYM_WIDTH-1:0] top, below, idx_n;
  logic [CW-1:0] count;
  logic full, empty, push, pop, zero, last_one, tab_we, tot_we;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic [STATE_WIDTH-1:0] cum_n;
  ans_sym_lifo #(.WIDTH(SYM_WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(sym_in),
    .top(top), .below(below), .full(full), .empty(empty), .count(count)
  );
  assign sym_rdy = (state == IDLE || state == FILL) && !full;
  assign push = sym_vld && sym_rdy;
  assign zero = state == DRAIN_ISSUE && !empty && enc_count == '0;
  assign enc_vld = state == DRAIN_ISSUE && !empty && enc_count != '0;
  assign pop = zero || (state == DRAIN_CHECK && enc_rdy);
  assign last_one = count == CW'(1);
  assign busy = state != IDLE;
  assign blk_done = state == DONE;
  assign enc_total = total;
  assign tab_we = cfg_we && state == IDLE;
  assign tot_we = cfg_total_we && state == IDLE;
  // The lookup register follows the stack top after this cycle's push/pop, so
  // it is already valid on the first DRAIN_ISSUE cycle; a same-cycle table
  // write is forwarded so the pushed symbol sees the new entry.
  assign idx_n = push ? sym_in : pop ? below : top;
  assign cnt_n = (tab_we && cfg_sym == idx_n) ? cfg_count : cnt_tab[idx_n];
  assign cum_n = (tab_we && cfg_sym == idx_n) ? cfg_cum : cum_tab[idx_n];
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FILL: state_n = push ? ((sym_last || count == CW'(DEPTH - 1)) ? DRAIN_ISSUE : FILL) : state;
      DRAIN_ISSUE: state_n = zero ? (last_one ? DONE : DRAIN_ISSUE) : ((enc_vld && enc_rdy) ? DRAIN_CHECK : DRAIN_ISSUE);
      DRAIN_CHECK: state_n = enc_rdy ? (last_one ? DONE : DRAIN_ISSUE) : DRAIN_WAIT;
      DRAIN_WAIT: state_n = enc_rdy ? DRAIN_ISSUE : DRAIN_WAIT;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      err_zero <= 1'b0;
      total <= STATE_WIDTH'(N);
      enc_count <= '0;
      enc_cum <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_tab[i] <= CNT_WIDTH'(1);
        cum_tab[i] <= STATE_WIDTH'(uniform_cum(i));
      end
    end else begin
      state <= state_n;
      err_zero <= err_zero | zero;
      enc_count <= cnt_n;
      enc_cum <= cum_n;
      if (tot_we) total <= cfg_total;
      if (tab_we) begin
        cnt_tab[cfg_sym] <= cfg_count;
        cum_tab[cfg_sym] <= cfg_cum;
      end
    end
endmodule

// File: tb/tb_ans_enc_sched.sv
// tb_ans_enc_sched: scoreboard bench with a small encoder handshake model.
module tb_ans_enc_sched;
  logic clk = 0, rst = 1;
  logic cfg_we = 0, cfg_total_we = 0, sym_last = 0, sym_vld = 0, enc_rdy;
  logic [3:0] cfg_sym = 0, sym_in = 0;
  logic [7:0] cfg_count = 0, enc_count;
  logic [15:0] cfg_cum = 0, cfg_total = 0, enc_cum, enc_total;
  logic sym_rdy, enc_vld, busy, blk_done, err_zero;
  int checks = 0, errors = 0, hs = 0, dones = 0, drops = 0, hs0, d0;
  logic [7:0] m_cnt [16];
  logic [15:0] m_cum [16];
  logic [15:0] m_total;
  logic [23:0] sb [$];

  ans_enc_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_count(cfg_count),
    .cfg_cum(cfg_cum), .cfg_total_we(cfg_total_we), .cfg_total(cfg_total),
    .sym_in(sym_in), .sym_last(sym_last), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .enc_count(enc_count), .enc_cum(enc_cum), .enc_total(enc_total), .enc_vld(enc_vld),
    .enc_rdy(enc_rdy), .busy(busy), .blk_done(blk_done), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 8'd1;
      m_cum[i] = 16'(i);
    end
    m_total = 16'd16;
  endtask

  task automatic send(input int s, input bit last);
    int n = 0;
    while (!sym_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sym_rdy_wait", sym_rdy, 1);
    if (m_cnt[s] != 0) sb.push_front({m_cnt[s], m_cum[s]});
    sym_in = 4'(s);
    sym_last = last;
    sym_vld = 1;
    @(posedge clk); #1;
    sym_vld = 0;
    sym_last = 0;
  endtask

  task automatic cfg_write(input int s, input int c, input int cu, input bit tw, input int t);
    cfg_sym = 4'(s);
    cfg_count = 8'(c);
    cfg_cum = 16'(cu);
    cfg_total = 16'(t);
    cfg_we = 1;
    cfg_total_we = tw;
    @(posedge clk); #1;
    cfg_we = 0;
    cfg_total_we = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic mark();
    hs0 = hs;
    d0 = dones;
  endtask

  task automatic block_end(input string tag, input int exp_hs);
    wait_idle();
    chk({tag, "_hs"}, hs - hs0, exp_hs);
    chk({tag, "_done"}, dones - d0, 1);
    chk({tag, "_sb"}, sb.size(), 0);
  endtask

  always @(negedge clk) if (blk_done) dones++;

  // Encoder model: every accepted symbol is checked against the scoreboard head;
  // a pending drop makes the encoder "emit" so the same symbol must come back.
  initial begin
    enc_rdy = 1;
    forever begin
      @(negedge clk);
      if (enc_vld && enc_rdy) begin
        hs++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          chk("enc_count", enc_count, sb[0][23:16]);
          chk("enc_cum", enc_cum, sb[0][15:0]);
        end
        chk("enc_total", enc_total, m_total);
        if (drops > 0) begin
          drops--;
          @(posedge clk); #1 enc_rdy = 0;
          @(negedge clk);
          chk("vld_gap", enc_vld, 0);
          @(posedge clk); #1 enc_rdy = 1;
        end else begin
          if (sb.size() > 0) void'(sb.pop_front());
          @(negedge clk);
          chk("vld_gap", enc_vld, 0);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sym_rdy", sym_rdy, 1);
    chk("rst_enc_vld", enc_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_err_zero", err_zero, 0);
    chk("rst_total", enc_total, 16);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;

    mark();
    send(3, 0);
    send(7, 0);
    send(1, 1);
    chk("t1_busy", busy, 1);
    block_end("t1", 3);

    cfg_write(5, 4, 10, 1, 32);
    m_cnt[5] = 4;
    m_cum[5] = 10;
    m_total = 32;
    mark();
    drops = 1;
    send(5, 1);
    block_end("t2", 2);

    cfg_write(2, 0, 2, 0, 0);
    m_cnt[2] = 0;
    mark();
    send(2, 0);
    send(4, 1);
    block_end("t3", 1);
    chk("t3_err_zero", err_zero, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_err_sticky", err_zero, 1);

    mark();
    for (int i = 0; i < 16; i++) send(i, 0);
    chk("t4_full_rdy", sym_rdy, 0);
    block_end("t4", 15);
    chk("t4_err_sticky", err_zero, 1);

    mark();
    send(9, 0);
    cfg_write(9, 7, 3, 1, 99);
    send(9, 1);
    block_end("t5", 2);

    mark();
    drops = 1;
    send(0, 0);
    send(1, 0);
    send(3, 0);
    send(4, 0);
    send(6, 1);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (enc_rdy && n < 100);
      chk("t6_wait_timeout", enc_rdy, 0);
    end
    @(posedge clk);
    #2 rst = 1;
    sb.delete();
    model_reset();
    #1;
    chk("t6_enc_vld", enc_vld, 0);
    chk("t6_sym_rdy", sym_rdy, 1);
    chk("t6_busy", busy, 0);
    chk("t6_err_zero", err_zero, 0);
    chk("t6_total", enc_total, 16);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    mark();
    send(8, 0);
    send(2, 1);
    block_end("t6", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
